// File: rtl/dmem_responder_if.sv
// ============================================================================
//  dmem_responder_if : request/acknowledge bus between an initiator and the
//                      dmem_responder data memory.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [1:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack_n;
   logic        err;

   modport master (
      output req, we, addr, size, wdata,
      input  rdata, ack_n, err
   );

   modport slave (
      input  req, we, addr, size, wdata,
      output rdata, ack_n, err
   );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  dmem_responder : wait-stated 32-bit data memory with a registered,
//                   active-low acknowledge and alignment error reporting.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
   parameter int WAIT   = 2,
   parameter int ADDR_W = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   dmem_responder_if.slave    bus_io
);

   localparam logic [3:0] C_WAIT  = 4'(WAIT);
   localparam int         C_DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [1:0]          lo_q;
   logic [1:0]          size_q;
   logic [31:0]         wdata_q;
   logic                ack_n_q, ack_n_d;
   logic                err_q, err_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                capture;
   logic                commit;
   logic                misaligned;
   logic [3:0]          byte_en;
   logic [31:0]         lane_data;
   logic                addr_unused;

   logic [31:0]         mem_q [C_DEPTH];

   assign addr_unused = ^bus_io.addr[31:ADDR_W+2];

   // Alignment, lane enables and lane-replicated write data of the captured request
   always_comb begin
      misaligned = 1'b0;
      byte_en    = 4'b0000;
      lane_data  = wdata_q;
      case (size_q)
         2'b00: begin
            byte_en   = 4'b0001 << lo_q;
            lane_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            misaligned = lo_q[0];
            byte_en    = lo_q[1] ? 4'b1100 : 4'b0011;
            lane_data  = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            misaligned = (lo_q != 2'b00);
            byte_en    = 4'b1111;
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A low ack_n means the acknowledged request may still be held
            if (bus_io.req && ack_n_q) begin
               state_d = S_BUSY;
               cnt_d   = C_WAIT;
               capture = 1'b1;
            end
         end
         S_BUSY: begin
            if (!bus_io.req) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               commit  = we_q && !misaligned;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      ack_n_d = (state_q != S_ACK);
      err_d   = (state_q == S_ACK) && misaligned;
      rdata_d = rdata_q;
      if (state_q == S_ACK) begin
         rdata_d = misaligned ? 32'd0 : mem_q[idx_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_n_q <= 1'b1;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         lo_q    <= 2'b00;
         size_q  <= 2'b00;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_n_q <= ack_n_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         if (capture) begin
            we_q    <= bus_io.we;
            idx_q   <= bus_io.addr[ADDR_W+1:2];
            lo_q    <= bus_io.addr[1:0];
            size_q  <= bus_io.size;
            wdata_q <= bus_io.wdata;
         end
      end
   end

   // Array contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (commit && byte_en[i]) begin
            mem_q[idx_q][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

   assign bus_io.ack_n = ack_n_q;
   assign bus_io.err   = err_q;
   assign bus_io.rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  tb_dmem_responder : scoreboard bench for two responders (WAIT=2 and WAIT=0).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

   typedef struct {
      bit          dut;
      int          cyc;
      bit          err;
      bit          chk;
      logic [31:0] rd;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        r_sel = 1'b0;
   logic        r_req = 1'b0;
   logic        r_we = 1'b0;
   logic [31:0] r_addr = 32'd0;
   logic [1:0]  r_size = 2'b00;
   logic [31:0] r_wdata = 32'd0;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   assign bus2.req   = r_req & ~r_sel;
   assign bus2.we    = r_we;
   assign bus2.addr  = r_addr;
   assign bus2.size  = r_size;
   assign bus2.wdata = r_wdata;
   assign bus0.req   = r_req & r_sel;
   assign bus0.we    = r_we;
   assign bus0.addr  = r_addr;
   assign bus0.size  = r_size;
   assign bus0.wdata = r_wdata;

   dmem_responder #(.WAIT(2), .ADDR_W(8)) u_dut2 (.clk(clk), .rst(rst), .bus_io(bus2));
   dmem_responder #(.WAIT(0), .ADDR_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus_io(bus0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic mon(input bit d, input logic an, input logic e, input logic [31:0] rd);
      exp_t x;
      if (an === 1'b0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack dut%0d at cycle %0d: got ack, required none", d, cyc);
         end else begin
            x = sb.pop_front();
            if (x.dut != d || x.cyc != cyc) begin
               errors++;
               $display("FAIL %s ack_timing: got dut%0d cycle %0d, required dut%0d cycle %0d",
                        x.name, d, cyc, x.dut, x.cyc);
            end
            checks++;
            if (e !== x.err) begin
               errors++;
               $display("FAIL %s err: got %b, required %b", x.name, e, x.err);
            end
            if (x.chk) begin
               checks++;
               if (rd !== x.rd) begin
                  errors++;
                  $display("FAIL %s rdata: got %h, required %h", x.name, rd, x.rd);
               end
            end
         end
      end else begin
         checks++;
         if (an !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs dut%0d cycle %0d: got ack_n=%b err=%b, required 1/0",
                     d, cyc, an, e);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(1'b0, bus2.ack_n, bus2.err, bus2.rdata);
         mon(1'b1, bus0.ack_n, bus0.err, bus0.rdata);
      end
   end

   task automatic access(input bit d, input bit w, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input bit ee, input bit chk,
                         input logic [31:0] er, input bit hold, input string nm);
      exp_t x;
      bit   got;
      @(negedge clk);
      r_sel = d; r_we = w; r_addr = a; r_size = sz; r_wdata = wd; r_req = 1'b1;
      x.dut = d; x.cyc = cyc + 1 + (d ? 0 : 2) + 2;
      x.err = ee; x.chk = chk; x.rd = er; x.name = nm;
      sb.push_back(x);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if ((d ? bus0.ack_n : bus2.ack_n) === 1'b0) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got no ack in 40 cycles, required one", nm);
      end
      if (!hold) r_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string nm);
      checks++;
      if (bus2.ack_n !== 1'b1 || bus2.err !== 1'b0 || bus2.rdata !== 32'd0 ||
          bus0.ack_n !== 1'b1 || bus0.err !== 1'b0 || bus0.rdata !== 32'd0) begin
         errors++;
         $display("FAIL %s: got ack_n=%b/%b err=%b/%b rdata=%h/%h, required 1 0 00000000",
                  nm, bus2.ack_n, bus0.ack_n, bus2.err, bus0.err, bus2.rdata, bus0.rdata);
      end
   endtask

   // Start a WAIT=2 write and kill it two cycles later, while still in BUSY
   task automatic kill_in_busy(input bit use_rst, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      r_sel = 1'b0; r_we = 1'b1; r_addr = a; r_size = 2'b10; r_wdata = wd; r_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      r_req = 1'b0;
      if (use_rst) begin
         rst = 1'b1;
         #1;
         check_reset_outputs("reset_mid_busy");
         @(negedge clk);
         rst = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2 check_reset_outputs("reset_state");
      @(negedge clk);
      rst = 1'b0;

      //     dut  we    addr        size   wdata          err  chk  rdata          hold
      access(0, 1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 0, 0, 32'h0,        0, "wr_word_10");
      access(0, 1'b0, 32'h10, 2'b10, 32'h0,        0, 1, 32'hDEADBEEF, 0, "rd_word_10");
      access(0, 1'b1, 32'h20, 2'b10, 32'h11223344, 0, 0, 32'h0,        0, "wr_init_20");
      access(0, 1'b1, 32'h22, 2'b00, 32'h000000AA, 0, 0, 32'h0,        0, "wr_byte_22");
      access(0, 1'b1, 32'h20, 2'b01, 32'h00005566, 0, 0, 32'h0,        0, "wr_half_20");
      access(0, 1'b0, 32'h20, 2'b10, 32'h0,        0, 1, 32'h11AA5566, 0, "rd_merged_20");
      access(0, 1'b0, 32'h23, 2'b00, 32'h0,        0, 1, 32'h11AA5566, 0, "rd_byte_23");
      access(0, 1'b0, 32'h22, 2'b01, 32'h0,        0, 1, 32'h11AA5566, 0, "rd_half_22");
      access(0, 1'b1, 32'h21, 2'b01, 32'h0000BEEF, 1, 1, 32'h0,        0, "wr_half_mis_21");
      access(0, 1'b0, 32'h22, 2'b10, 32'h0,        1, 1, 32'h0,        0, "rd_word_mis_22");
      access(0, 1'b0, 32'h20, 2'b11, 32'h0,        1, 1, 32'h0,        0, "rd_size_rsvd");
      access(0, 1'b0, 32'h20, 2'b10, 32'h0,        0, 1, 32'h11AA5566, 0, "rd_unchanged_20");

      access(0, 1'b1, 32'h13, 2'b00, 32'h00000077, 0, 0, 32'h0,        1, "held_wr_byte_13");
      access(0, 1'b1, 32'h10, 2'b01, 32'h00001234, 0, 0, 32'h0,        1, "held_wr_half_10");
      access(0, 1'b0, 32'h10, 2'b10, 32'h0,        0, 1, 32'h77AD1234, 0, "held_rd_10");

      kill_in_busy(1'b0, 32'h10, 32'hCAFEF00D);
      access(0, 1'b0, 32'h10, 2'b10, 32'h0,        0, 1, 32'h77AD1234, 0, "rd_after_abort");
      kill_in_busy(1'b1, 32'h20, 32'h12345678);
      access(0, 1'b0, 32'h20, 2'b10, 32'h0,        0, 1, 32'h11AA5566, 0, "rd_after_reset");

      access(1, 1'b1, 32'h3FC, 2'b10, 32'h0BADCAFE, 0, 0, 32'h0,       0, "w0_wr_3fc");
      access(1, 1'b0, 32'h7FC, 2'b10, 32'h0,        0, 1, 32'h0BADCAFE, 0, "w0_rd_alias_7fc");
      access(1, 1'b0, 32'h3FC, 2'b10, 32'h0,        0, 1, 32'h0BADCAFE, 0, "w0_rd_3fc");
      access(1, 1'b0, 32'h3FE, 2'b10, 32'h0,        1, 1, 32'h0,        0, "w0_rd_mis_3fe");

      repeat (6) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending acks, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT, default 2, giving the number of wait-state cycles between request capture and acknowledge (legal range 0..15).
REQ-002 SHALL have parameter ADDR_W, default 8, giving the word-index width; memory depth is 2**ADDR_W 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 1 bit: the initiator requests an access and holds all request fields stable until it sees ack_n low.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, 32 bits: byte address; bits [ADDR_W+1:2] select the word, and higher bits are ignored (address wraps).
REQ-008 SHALL have port size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-009 SHALL have port wdata, input, 32 bits: write data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-010 SHALL have port rdata, output, 32 bits: read data, i.e. the full addressed word, unshifted.
REQ-011 SHALL have port ack_n, output, 1 bit, active-low acknowledge; it is consumed by the processor stall logic, which interlocks while ack_n = 1.
REQ-012 SHALL have port err, output, 1 bit: high together with ack_n = 0 when the access is misaligned or size = 11.

Function
REQ-013 SHALL implement a three-state FSM IDLE, BUSY, ACK; all outputs SHALL be registered.
REQ-014 IDLE: when req = 1 at a clock edge, SHALL load the wait counter with WAIT and go to BUSY.
REQ-015 BUSY: SHALL decrement the counter each cycle; when the counter = 0 and req = 1, SHALL go to ACK.
REQ-016 With WAIT = 0, BUSY SHALL last one cycle; the first ack_n = 0 cycle SHALL therefore come WAIT+2 edges after the req-capture edge.
REQ-017 ACK: ack_n SHALL be 0 for exactly one cycle; rdata and err SHALL be valid in that cycle; the next state SHALL always be IDLE.
REQ-018 After ACK, the FSM SHALL spend at least one cycle in IDLE before capturing a new request, so a held req is never acknowledged twice.
REQ-019 A write SHALL be committed to the array on the BUSY->ACK edge only.
REQ-020 Write byte enables SHALL be: byte -> lane addr[1:0]; halfword -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes. Lanes not enabled SHALL be left unchanged.
REQ-021 Misalignment rule: halfword with addr[0] = 1, or word with addr[1:0] != 00, or size = 11, SHALL give err = 1, no array write, and rdata = 0.
REQ-022 For a read, rdata SHALL hold the word at the captured index as it was before the ACK cycle.
REQ-023 If req drops while in BUSY, SHALL abort to IDLE next edge, with no write, ack_n kept at 1 and err = 0.
REQ-024 Outside ACK, ack_n SHALL be 1 and err SHALL be 0; rdata SHALL hold its last value.
REQ-025 Request fields SHALL be sampled on the IDLE->BUSY edge; later changes to them SHALL not affect the transaction (initiator contract violation, no checking).

Reset
REQ-026 While rst = 1, SHALL force state = IDLE, counter = 0, ack_n = 1, err = 0, rdata = 0, asynchronously.
REQ-027 Reset mid-BUSY SHALL discard the pending transaction with no array write; reset SHALL NOT clear array contents.
REQ-028 The first request after rst falls SHALL be captured on the first rising edge with req = 1.

Verification
REQ-029 WAIT = 2: write word 0xDEADBEEF to addr 0x10, then read addr 0x10 -> ack_n low exactly 4 edges after each capture; rdata = 0xDEADBEEF; err = 0.
REQ-030 Init word at 0x20 = 0x11223344; byte write 0xAA to 0x22, then halfword write 0x5566 to 0x20 -> a word read returns 0x11AA5566.
REQ-031 Halfword write to 0x21, and word read of 0x22 -> ack_n pulses once for each, err = 1, rdata = 0, memory unchanged.
REQ-032 req held high continuously across 3 accesses -> exactly one ack_n = 0 cycle per access, with an IDLE gap cycle between them.
REQ-033 req dropped in BUSY, or rst pulsed in BUSY during a write -> no ack, target word unchanged; next request completes normally.
REQ-034 WAIT = 0, read of addr 0x3FC with ADDR_W = 8 -> ack_n low 2 edges after capture; addr 0x7FC aliases to the same word.
